multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Parametrised control FSM for the multicycle RV32I core.
- Drives PC, IR, memory, register-file and ALU-mux control from the IR opcode, `alu_bcond` and memory-latency tracking.
- Generalises the fixed 4-cycle fetch/memory control: configurable instruction- and data-memory latency, non-taken-branch PC+4 path, ECALL halt state, retired-instruction counter.

Parameters:
- IMEM_LAT, 4, instruction-fetch latency in cycles (>=1).
- DMEM_LAT, 4, data-memory access latency in cycles (>=1).
- CNT_W, 32, width of retired-instruction counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- part_of_inst  in  7  IR[6:0] opcode; valid from ID onward, ignored in IF.
- alu_bcond  in  1  branch compare result, valid in EX.
- halt_req  in  1  ECALL halt condition (x17==10), sampled in ID.
- pc_write  out  1  unconditional PC write.
- pc_write_cond  out  1  PC write gated by alu_bcond.
- pc_source  out  1  0=ALU result, 1=ALUOut.
- i_or_d  out  1  0=PC address, 1=ALUOut address.
- mem_read  out  1  memory read.
- mem_write  out  1  memory write.
- ir_write  out  1  IR load.
- mem_to_reg  out  2  00=ALUOut, 01=MDR, 10=ALU result (PC+4).
- reg_write  out  1  register file write.
- alu_src_a  out  1  0=PC, 1=rs1.
- alu_src_b  out  2  00=rs2, 01=const 4, 10=imm.
- alu_op  out  2  00=add, 01=branch compare, 10=funct decode.
- halted  out  1  FSM is in HALT.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- States: IF, ID, EX, MEM, WB, HALT.
- Outputs are Moore decode of state plus opcode. Any signal not listed for a state is 0.
- Reset (async, any time, mid-instruction included): state=IF, wait counter=IMEM_LAT-1, instret=0, all outputs 0 except IF decode.
- Wait counter, width $clog2(max(IMEM_LAT,DMEM_LAT)+1):
  - loaded with LAT-1 on entry to IF or MEM;
  - decrements each cycle in that state;
  - phase ends in the cycle counter==0, so LAT=1 means a single cycle.
- IF: mem_read=1, i_or_d=0. ir_write=1 only in the final cycle. Final cycle -> ID.
- ID: alu_src_a=0, alu_src_b=10, alu_op=00, so ALUOut<=PC+imm. Next state:
  - JAL -> WB;
  - ECALL with halt_req -> HALT;
  - ECALL without halt_req -> WB;
  - unknown opcode -> WB (NOP);
  - else -> EX.
- EX, by opcode:
  - ARITHMETIC: a=1, b=00, op=10 -> WB.
  - ARITHMETIC_IMM: a=1, b=10, op=10 -> WB.
  - LOAD/STORE/JALR: a=1, b=10, op=00 -> MEM (LOAD/STORE) or WB (JALR).
  - BRANCH: a=1, b=00, op=01, pc_write_cond=1, pc_source=1; alu_bcond=1 -> IF, else -> WB.
- MEM:
  - i_or_d=1 throughout.
  - LOAD: mem_read=1.
  - STORE: mem_write=1 every cycle.
  - Final cycle -> WB.
- WB: a=0, b=01, op=00 (ALU=PC+4), pc_write=1, then -> IF.
  - pc_source=1 for JAL/JALR, 0 otherwise.
  - reg_write=1 for ARITHMETIC, ARITHMETIC_IMM, LOAD, JAL, JALR.
  - mem_to_reg: 00 for arithmetic, 01 for LOAD, 10 for JAL/JALR.
- HALT: halted=1, all control outputs 0, stays until reset.
- instret: +1 on every transition into IF from EX or WB; wraps modulo 2^CNT_W; not incremented for the halting ECALL.
- Default-parameter latencies in cycles:
  - R/I: 7;
  - LOAD/STORE: 11;
  - taken branch: 6; not-taken branch: 7;
  - JAL: 6; JALR: 7.

Optional Feature:
MEM_HANDSHAKE_EN:
- Defined: adds input `mem_ready` (1 bit). IF and MEM end in the cycle `mem_ready`=1 instead of on counter==0; the wait counter and the IMEM_LAT/DMEM_LAT parameters are ignored. Control outputs hold steady while waiting. `mem_ready` asserted in the first cycle gives a single-cycle phase.
- Undefined: no `mem_ready` port; counter-based latency as above.

Test Plan:
- Reset low mid-MEM of a LOAD -> next cycle state IF, instret=0, mem_read=1, i_or_d=0.
- ADD, defaults -> ir_write pulses in cycle 4 only; WB in cycle 7 with reg_write=1, mem_to_reg=00, pc_write=1; instret 0->1.
- LOAD with DMEM_LAT=2, IMEM_LAT=1 -> IF(1), ID, EX, MEM(2), WB: 6 cycles total; WB mem_to_reg=01.
- BEQ with alu_bcond=1 -> EX asserts pc_write_cond=1, pc_source=1, next state IF (6 cycles). With alu_bcond=0 -> WB with pc_write=1, reg_write=0.
- JAL -> ID goes directly to WB; WB has pc_source=1, mem_to_reg=10, reg_write=1.
- ECALL with halt_req=1 -> HALT after ID; halted=1, all controls 0 for 20 cycles, instret unchanged. With MEM_HANDSHAKE_EN, holding mem_ready=0 for 10 cycles keeps the FSM in IF with mem_read=1.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_if.sv
// multicycle_ctrl_fsm_if: control bus between the multicycle RV32I control FSM
// and its datapath. The FSM uses the master modport and the datapath the slave one.
// Optional MEM_HANDSHAKE_EN adds the mem_ready strobe from memory.
interface multicycle_ctrl_fsm_if #(
   parameter int CNT_W = 32
);
   logic [6:0]       part_of_inst;
   logic             alu_bcond;
   logic             halt_req;
`ifdef MEM_HANDSHAKE_EN
   logic             mem_ready;
`endif
   logic             pc_write;
   logic             pc_write_cond;
   logic             pc_source;
   logic             i_or_d;
   logic             mem_read;
   logic             mem_write;
   logic             ir_write;
   logic [1:0]       mem_to_reg;
   logic             reg_write;
   logic             alu_src_a;
   logic [1:0]       alu_src_b;
   logic [1:0]       alu_op;
   logic             halted;
   logic [CNT_W-1:0] instret;

   modport master (
`ifdef MEM_HANDSHAKE_EN
      input  mem_ready,
`endif
      input  part_of_inst, alu_bcond, halt_req,
      output pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
      output ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
      output halted, instret
   );

   modport slave (
`ifdef MEM_HANDSHAKE_EN
      output mem_ready,
`endif
      output part_of_inst, alu_bcond, halt_req,
      input  pc_write, pc_write_cond, pc_source, i_or_d, mem_read, mem_write,
      input  ir_write, mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op,
      input  halted, instret
   );
endinterface

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm: control FSM of the multicycle RV32I core.
// IF/ID/EX/MEM/WB/HALT with configurable fetch and data latencies and a
// retired-instruction counter. Outputs are registered: each transition loads
// the control word of the state being entered.
// Optional MEM_HANDSHAKE_EN: IF and MEM end on mem_ready instead of the counter.
module multicycle_ctrl_fsm #(
   parameter int IMEM_LAT = 4,
   parameter int DMEM_LAT = 4,
   parameter int CNT_W    = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   multicycle_ctrl_fsm_if.master bus
);
   localparam int MAX_LAT = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
   localparam int WAIT_W  = $clog2(MAX_LAT + 1);
   localparam logic [WAIT_W-1:0] IF_LOAD  = WAIT_W'(IMEM_LAT - 1);
   localparam logic [WAIT_W-1:0] MEM_LOAD = WAIT_W'(DMEM_LAT - 1);

   localparam logic [6:0] OP_ARITH     = 7'b0110011;
   localparam logic [6:0] OP_ARITH_IMM = 7'b0010011;
   localparam logic [6:0] OP_LOAD      = 7'b0000011;
   localparam logic [6:0] OP_STORE     = 7'b0100011;
   localparam logic [6:0] OP_BRANCH    = 7'b1100011;
   localparam logic [6:0] OP_JAL       = 7'b1101111;
   localparam logic [6:0] OP_JALR      = 7'b1100111;
   localparam logic [6:0] OP_ECALL     = 7'b1110011;

   typedef enum logic [2:0] {S_IF, S_ID, S_EX, S_MEM, S_WB, S_HALT} state_t;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       halted;
   } ctrl_t;

   state_t            state_reg;
   logic [WAIT_W-1:0] wait_reg;
   logic [CNT_W-1:0]  instret_reg;
   ctrl_t             ctrl_reg;
   logic              phase_done;
   logic              if_last_entry;
   logic              if_last_stay;
   logic [6:0]        op;

   assign op = bus.part_of_inst;

`ifdef MEM_HANDSHAKE_EN
   // Memory tells us when the phase ends; ir_write is gated by mem_ready below.
   assign phase_done    = bus.mem_ready;
   assign if_last_entry = 1'b1;
   assign if_last_stay  = 1'b1;
`else
   // Phase ends when the wait counter has run down to zero.
   assign phase_done    = (wait_reg == '0);
   assign if_last_entry = (IMEM_LAT == 1);
   assign if_last_stay  = (wait_reg == WAIT_W'(1));
`endif

   // Opcodes that need an EX cycle; JAL, ECALL and unknown go straight to WB.
   function automatic logic needs_ex(input logic [6:0] o);
      return (o == OP_ARITH) || (o == OP_ARITH_IMM) || (o == OP_LOAD) ||
             (o == OP_STORE) || (o == OP_BRANCH) || (o == OP_JALR);
   endfunction

   // Control word for a state; last marks the final IF cycle (IR load).
   function automatic ctrl_t decode(input state_t s, input logic [6:0] o, input logic last);
      ctrl_t c;
      c = '0;
      case (s)
         S_IF: begin
            c.mem_read = 1'b1;
            c.ir_write = last;
         end
         S_ID: c.alu_src_b = 2'b10;
         S_EX: begin
            c.alu_src_a = 1'b1;
            if (o == OP_ARITH) begin
               c.alu_op = 2'b10;
            end else if (o == OP_ARITH_IMM) begin
               c.alu_src_b = 2'b10;
               c.alu_op    = 2'b10;
            end else if (o == OP_BRANCH) begin
               c.alu_op        = 2'b01;
               c.pc_write_cond = 1'b1;
               c.pc_source     = 1'b1;
            end else begin
               c.alu_src_b = 2'b10;
            end
         end
         S_MEM: begin
            c.i_or_d    = 1'b1;
            c.mem_read  = (o == OP_LOAD);
            c.mem_write = (o == OP_STORE);
         end
         S_WB: begin
            c.alu_src_b = 2'b01;
            c.pc_write  = 1'b1;
            c.pc_source = (o == OP_JAL) || (o == OP_JALR);
            c.reg_write = (o == OP_ARITH) || (o == OP_ARITH_IMM) || (o == OP_LOAD) ||
                          (o == OP_JAL) || (o == OP_JALR);
            if (o == OP_LOAD)
               c.mem_to_reg = 2'b01;
            else if ((o == OP_JAL) || (o == OP_JALR))
               c.mem_to_reg = 2'b10;
         end
         S_HALT: c.halted = 1'b1;
         default: c = '0;
      endcase
      return c;
   endfunction

   // State sequencing, latency counting, retire counting and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg   <= S_IF;
         wait_reg    <= IF_LOAD;
         instret_reg <= '0;
         ctrl_reg    <= decode(S_IF, 7'd0, IMEM_LAT == 1);
      end else begin
         case (state_reg)
            S_IF: begin
               if (phase_done) begin
                  state_reg <= S_ID;
                  ctrl_reg  <= decode(S_ID, op, 1'b0);
               end else begin
                  wait_reg <= wait_reg - WAIT_W'(1);
                  ctrl_reg <= decode(S_IF, op, if_last_stay);
               end
            end
            S_ID: begin
               if ((op == OP_ECALL) && bus.halt_req) begin
                  state_reg <= S_HALT;
                  ctrl_reg  <= decode(S_HALT, op, 1'b0);
               end else if (needs_ex(op)) begin
                  state_reg <= S_EX;
                  ctrl_reg  <= decode(S_EX, op, 1'b0);
               end else begin
                  state_reg <= S_WB;
                  ctrl_reg  <= decode(S_WB, op, 1'b0);
               end
            end
            S_EX: begin
               if ((op == OP_BRANCH) && bus.alu_bcond) begin
                  state_reg   <= S_IF;
                  wait_reg    <= IF_LOAD;
                  instret_reg <= instret_reg + CNT_W'(1);
                  ctrl_reg    <= decode(S_IF, op, if_last_entry);
               end else if ((op == OP_LOAD) || (op == OP_STORE)) begin
                  state_reg <= S_MEM;
                  wait_reg  <= MEM_LOAD;
                  ctrl_reg  <= decode(S_MEM, op, 1'b0);
               end else begin
                  state_reg <= S_WB;
                  ctrl_reg  <= decode(S_WB, op, 1'b0);
               end
            end
            S_MEM: begin
               if (phase_done) begin
                  state_reg <= S_WB;
                  ctrl_reg  <= decode(S_WB, op, 1'b0);
               end else begin
                  wait_reg <= wait_reg - WAIT_W'(1);
                  ctrl_reg <= decode(S_MEM, op, 1'b0);
               end
            end
            S_WB: begin
               state_reg   <= S_IF;
               wait_reg    <= IF_LOAD;
               instret_reg <= instret_reg + CNT_W'(1);
               ctrl_reg    <= decode(S_IF, op, if_last_entry);
            end
            S_HALT: ctrl_reg <= decode(S_HALT, op, 1'b0);
            default: begin
               state_reg <= S_IF;
               wait_reg  <= IF_LOAD;
               ctrl_reg  <= decode(S_IF, op, if_last_entry);
            end
         endcase
      end
   end

   assign bus.pc_write      = ctrl_reg.pc_write;
   assign bus.pc_write_cond = ctrl_reg.pc_write_cond;
   assign bus.pc_source     = ctrl_reg.pc_source;
   assign bus.i_or_d        = ctrl_reg.i_or_d;
   assign bus.mem_read      = ctrl_reg.mem_read;
   assign bus.mem_write     = ctrl_reg.mem_write;
`ifdef MEM_HANDSHAKE_EN
   assign bus.ir_write      = ctrl_reg.ir_write & bus.mem_ready;
`else
   assign bus.ir_write      = ctrl_reg.ir_write;
`endif
   assign bus.mem_to_reg    = ctrl_reg.mem_to_reg;
   assign bus.reg_write     = ctrl_reg.reg_write;
   assign bus.alu_src_a     = ctrl_reg.alu_src_a;
   assign bus.alu_src_b     = ctrl_reg.alu_src_b;
   assign bus.alu_op        = ctrl_reg.alu_op;
   assign bus.halted        = ctrl_reg.halted;
   assign bus.instret       = instret_reg;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm: bench for multicycle_ctrl_fsm with two instances
// (IMEM/DMEM latency 4/4 and 1/2). An instruction-level model expands each
// instruction into its expected per-cycle control words.
module tb_multicycle_ctrl_fsm;
   localparam int CNT_W = 32;
`ifdef MEM_HANDSHAKE_EN
   localparam int IL0 = 1, DL0 = 1, IL1 = 1, DL1 = 1;
`else
   localparam int IL0 = 4, DL0 = 4, IL1 = 1, DL1 = 2;
`endif

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_ECALL  = 7'b1110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       pc_source;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic [1:0] mem_to_reg;
      logic       reg_write;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       halted;
   } ctrl_t;

   typedef struct {
      int         w;
      logic [6:0] op;
      logic       bc;
      int         cycles;
   } vec_t;

   logic clk = 1'b0;
   logic rst0_n, rst1_n;
   always #5 clk = ~clk;

   multicycle_ctrl_fsm_if #(.CNT_W(CNT_W)) bus0 ();
   multicycle_ctrl_fsm_if #(.CNT_W(CNT_W)) bus1 ();

   multicycle_ctrl_fsm #(.IMEM_LAT(4), .DMEM_LAT(4), .CNT_W(CNT_W)) dut0 (
      .clk(clk), .reset(rst0_n), .bus(bus0));
   multicycle_ctrl_fsm #(.IMEM_LAT(1), .DMEM_LAT(2), .CNT_W(CNT_W)) dut1 (
      .clk(clk), .reset(rst1_n), .bus(bus1));

   int         n_checks = 0;
   int         n_fail = 0;
   int         model_cnt[2];
   ctrl_t      exp_q[$];
   bit         exp_retire;
   bit         exp_halt;
   logic [6:0] pool[10];
   vec_t       vecs[12];

   function automatic ctrl_t get_ctrl(input int w);
      if (w == 0)
         return {bus0.pc_write, bus0.pc_write_cond, bus0.pc_source, bus0.i_or_d, bus0.mem_read,
                 bus0.mem_write, bus0.ir_write, bus0.mem_to_reg, bus0.reg_write, bus0.alu_src_a,
                 bus0.alu_src_b, bus0.alu_op, bus0.halted};
      return {bus1.pc_write, bus1.pc_write_cond, bus1.pc_source, bus1.i_or_d, bus1.mem_read,
              bus1.mem_write, bus1.ir_write, bus1.mem_to_reg, bus1.reg_write, bus1.alu_src_a,
              bus1.alu_src_b, bus1.alu_op, bus1.halted};
   endfunction

   function automatic logic [CNT_W-1:0] get_instret(input int w);
      return (w == 0) ? bus0.instret : bus1.instret;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   task automatic set_inst(input int w, input logic [6:0] op, input logic bc, input logic hr);
      if (w == 0) begin
         bus0.part_of_inst = op; bus0.alu_bcond = bc; bus0.halt_req = hr;
      end else begin
         bus1.part_of_inst = op; bus1.alu_bcond = bc; bus1.halt_req = hr;
      end
   endtask

   // Expected control words for the stages after fetch/decode.
   function automatic ctrl_t ex_word(input logic [6:0] op);
      ctrl_t c = '0;
      c.alu_src_a = 1'b1;
      case (op)
         OP_R:      c.alu_op = 2'b10;
         OP_I:      begin c.alu_src_b = 2'b10; c.alu_op = 2'b10; end
         OP_BRANCH: begin c.alu_op = 2'b01; c.pc_write_cond = 1'b1; c.pc_source = 1'b1; end
         default:   c.alu_src_b = 2'b10;
      endcase
      return c;
   endfunction

   function automatic ctrl_t wb_word(input logic [6:0] op);
      ctrl_t c = '0;
      c.alu_src_b = 2'b01;
      c.pc_write  = 1'b1;
      case (op)
         OP_R, OP_I: c.reg_write = 1'b1;
         OP_LOAD:    begin c.reg_write = 1'b1; c.mem_to_reg = 2'b01; end
         OP_JAL, OP_JALR: begin c.reg_write = 1'b1; c.mem_to_reg = 2'b10; c.pc_source = 1'b1; end
         default: ;
      endcase
      return c;
   endfunction

   // Expand one instruction into its cycle-by-cycle control words.
   task automatic build_expect(input int il, input int dl, input logic [6:0] op,
                               input logic bc, input logic hr);
      ctrl_t c;
      exp_q.delete();
      exp_retire = 1'b1;
      exp_halt   = 1'b0;
      for (int k = 0; k < il; k++) begin
         c = '0; c.mem_read = 1'b1; c.ir_write = (k == il - 1);
         exp_q.push_back(c);
      end
      c = '0; c.alu_src_b = 2'b10;
      exp_q.push_back(c);
      case (op)
         OP_ECALL: begin
            if (hr) begin
               exp_halt = 1'b1; exp_retire = 1'b0;
            end else begin
               exp_q.push_back(wb_word(op));
            end
         end
         OP_JAL: exp_q.push_back(wb_word(op));
         OP_R, OP_I, OP_JALR: begin
            exp_q.push_back(ex_word(op));
            exp_q.push_back(wb_word(op));
         end
         OP_LOAD, OP_STORE: begin
            exp_q.push_back(ex_word(op));
            for (int k = 0; k < dl; k++) begin
               c = '0; c.i_or_d = 1'b1;
               c.mem_read = (op == OP_LOAD); c.mem_write = (op == OP_STORE);
               exp_q.push_back(c);
            end
            exp_q.push_back(wb_word(op));
         end
         OP_BRANCH: begin
            exp_q.push_back(ex_word(op));
            if (!bc) exp_q.push_back(wb_word(op));
         end
         default: exp_q.push_back(wb_word(op));
      endcase
   endtask

   // Entered at a negedge inside the first IF cycle; leaves at the next one.
   task automatic run_inst(input int w, input logic [6:0] op, input logic bc, input logic hr);
      ctrl_t h;
      set_inst(w, op, bc, hr);
      build_expect((w == 0) ? IL0 : IL1, (w == 0) ? DL0 : DL1, op, bc, hr);
      chk("instret_start", 64'(get_instret(w)), 64'(model_cnt[w]));
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("ctrl dut%0d op=%b cyc%0d", w, op, i), 64'(get_ctrl(w)), 64'(exp_q[i]));
         @(negedge clk);
      end
      if (exp_retire) model_cnt[w]++;
      if (exp_halt) begin
         h = '0; h.halted = 1'b1;
         for (int i = 0; i < 20; i++) begin
            chk($sformatf("halt_ctrl cyc%0d", i), 64'(get_ctrl(w)), 64'(h));
            chk("halt_instret", 64'(get_instret(w)), 64'(model_cnt[w]));
            @(negedge clk);
         end
      end
      $display("dut%0d op=%b bcond=%0d halt_req=%0d cycles=%0d instret_model=%0d",
               w, op, bc, hr, exp_q.size(), model_cnt[w]);
   endtask

   // Reset one instance (the other is parked in reset); release at a negedge.
   task automatic do_reset(input int w);
      ctrl_t c;
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      @(negedge clk);
      c = '0; c.mem_read = 1'b1; c.ir_write = (((w == 0) ? IL0 : IL1) == 1);
      chk("reset_ctrl", 64'(get_ctrl(w)), 64'(c));
      chk("reset_instret", 64'(get_instret(w)), 64'd0);
      if (w == 0) rst0_n = 1'b1; else rst1_n = 1'b1;
      model_cnt[w] = 0;
   endtask

   // Cycles from the first IF cycle until instret steps.
   task automatic measure(input vec_t v);
      int n;
      do_reset(v.w);
      set_inst(v.w, v.op, v.bc, 1'b0);
      n = 0;
      for (int k = 1; k <= 50; k++) begin
         @(negedge clk);
         if (get_instret(v.w) != 0) begin
            n = k;
            break;
         end
      end
      chk($sformatf("latency dut%0d op=%b bc=%0d", v.w, v.op, v.bc), 64'(n), 64'(v.cycles));
      chk("latency_instret", 64'(get_instret(v.w)), 64'd1);
      $display("dut%0d op=%b bcond=%0d measured=%0d expected=%0d", v.w, v.op, v.bc, n, v.cycles);
   endtask

   initial begin
      ctrl_t c;
      rst0_n = 1'b0;
      rst1_n = 1'b0;
      set_inst(0, 7'd0, 1'b0, 1'b0);
      set_inst(1, 7'd0, 1'b0, 1'b0);
`ifdef MEM_HANDSHAKE_EN
      bus0.mem_ready = 1'b1;
      bus1.mem_ready = 1'b1;
`endif
      pool = '{OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_BRANCH,
               OP_JAL, OP_JALR, OP_ECALL, OP_LUI};
      vecs = '{'{0, OP_R, 1'b0, 7},      '{0, OP_I, 1'b0, 7},
               '{0, OP_LOAD, 1'b0, 11},  '{0, OP_STORE, 1'b0, 11},
               '{0, OP_BRANCH, 1'b1, 6}, '{0, OP_BRANCH, 1'b0, 7},
               '{0, OP_JAL, 1'b0, 6},    '{0, OP_JALR, 1'b0, 7},
               '{0, OP_ECALL, 1'b0, 6},  '{0, OP_LUI, 1'b0, 6},
               '{1, OP_LOAD, 1'b0, 6},   '{1, OP_BRANCH, 1'b1, 3}};
      @(negedge clk);

`ifndef MEM_HANDSHAKE_EN
      foreach (vecs[i]) measure(vecs[i]);
`endif

      // Directed sequences on the default instance.
      do_reset(0);
      run_inst(0, OP_R, 1'b0, 1'b0);
      run_inst(0, OP_BRANCH, 1'b1, 1'b0);
      run_inst(0, OP_BRANCH, 1'b0, 1'b0);
      run_inst(0, OP_JAL, 1'b0, 1'b0);
      do_reset(1);
      run_inst(1, OP_LOAD, 1'b0, 1'b0);

      // Asynchronous reset in the middle of a LOAD memory phase.
      do_reset(0);
      run_inst(0, OP_R, 1'b0, 1'b0);
      set_inst(0, OP_LOAD, 1'b0, 1'b0);
      repeat (IL0 + 2) @(negedge clk);
      c = '0; c.i_or_d = 1'b1; c.mem_read = 1'b1;
      chk("mid_mem_ctrl", 64'(get_ctrl(0)), 64'(c));
      #2 rst0_n = 1'b0;
      #1;
      c = '0; c.mem_read = 1'b1; c.ir_write = (IL0 == 1);
      chk("async_reset_ctrl", 64'(get_ctrl(0)), 64'(c));
      chk("async_reset_instret", 64'(get_instret(0)), 64'd0);
      @(negedge clk);
      rst0_n = 1'b1;
      model_cnt[0] = 0;
      run_inst(0, OP_R, 1'b0, 1'b0);

      // ECALL halt and non-halting ECALL.
      do_reset(0);
      run_inst(0, OP_R, 1'b0, 1'b0);
      run_inst(0, OP_ECALL, 1'b0, 1'b1);
      do_reset(0);
      run_inst(0, OP_ECALL, 1'b0, 1'b0);

`ifdef MEM_HANDSHAKE_EN
      // Fetch stalls while memory is not ready.
      do_reset(0);
      bus0.mem_ready = 1'b0;
      for (int i = 0; i < 10; i++) begin
         c = '0; c.mem_read = 1'b1;
         chk($sformatf("stall_ctrl cyc%0d", i), 64'(get_ctrl(0)), 64'(c));
         @(negedge clk);
      end
      bus0.mem_ready = 1'b1;
      run_inst(0, OP_R, 1'b0, 1'b0);
`endif

      // Random instruction streams against the model, both instances.
      for (int w = 0; w < 2; w++) begin
         do_reset(w);
         for (int n = 0; n < 100; n++) begin
            logic [6:0] op;
            logic       bc, hr;
            op = pool[$urandom_range(0, 9)];
            bc = 1'($urandom_range(0, 1));
            hr = (op == OP_ECALL) && ($urandom_range(0, 3) == 0);
            run_inst(w, op, bc, hr);
            if (exp_halt) do_reset(w);
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end
endmodule
